line_fill_responder: RTL and testbench

- Memory-side responder for the cache line-fill/writeback interface. It answers line requests issued by the D-cache MSHRs and the I-cache miss handler.
- Contents:
  - a small in-order request queue;
  - a fixed-latency access FSM;
  - a line-granular backing store.
- Used as the simulation and FPGA memory endpoint behind the caches. It lets cache refill logic be verified without an external memory controller.

---
 rtl/line_fill_responder.sv | 131 +++++++++++++
 tb/tb_line_fill_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
// Memory-side line-fill/writeback responder: in-order request queue, fixed-latency
// access FSM and a line-granular backing store used as the cache memory endpoint.
module line_fill_responder #(
    parameter int LINE_BYTE_NUM = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 1,
    parameter int MEM_LINE_NUM  = 1024,
    parameter int LATENCY       = 4,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reqValid,
    output logic                       reqReady,
    input  logic                       reqIsWrite,
    input  logic [ADDR_WIDTH-1:0]      reqAddr,
    input  logic [LINE_BYTE_NUM*8-1:0] reqWriteData,
    input  logic [ID_WIDTH-1:0]        reqID,
    output logic                       rspValid,
    input  logic                       rspReady,
    output logic                       rspIsWrite,
    output logic [ID_WIDTH-1:0]        rspID,
    output logic [LINE_BYTE_NUM*8-1:0] rspData,
    output logic                       busy
);

    localparam int DATA_W = LINE_BYTE_NUM * 8;
    localparam int OFF_W  = $clog2(LINE_BYTE_NUM);
    localparam int IDX_W  = $clog2(MEM_LINE_NUM);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic              q_write [QUEUE_DEPTH];
    logic [IDX_W-1:0]  q_idx   [QUEUE_DEPTH];
    logic [DATA_W-1:0] q_data  [QUEUE_DEPTH];
    logic [ID_WIDTH-1:0] q_id  [QUEUE_DEPTH];
    logic [DATA_W-1:0] store   [MEM_LINE_NUM];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    state_t            state;
    logic [CNT_W-1:0]  counter;

    logic push;
    logic pop;
    logic access_done;
    logic store_we;
    logic unused_addr;

    // Only the line-index field of the address matters; everything else aliases.
    assign unused_addr = ^reqAddr;

    assign reqReady    = (count != (PTR_W + 1)'(QUEUE_DEPTH));
    assign busy        = (count != '0) || (state != IDLE);
    assign push        = reqValid && reqReady;
    assign pop         = (state == RESP) && rspValid && rspReady;
    assign access_done = (state == WAIT) && (counter == '0);
    assign store_we    = access_done && q_write[head];

    always_ff @(posedge clk) begin
        if (push) begin
            q_write[tail] <= reqIsWrite;
            q_idx[tail]   <= reqAddr[OFF_W +: IDX_W];
            q_data[tail]  <= reqWriteData;
            q_id[tail]    <= reqID;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Writes land on the same edge the FSM leaves WAIT, so any later read sees them.
    always_ff @(posedge clk) begin
        if (store_we)
            store[q_idx[head]] <= q_data[head];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            rspValid   <= 1'b0;
            rspIsWrite <= 1'b0;
            rspID      <= '0;
            rspData    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state   <= WAIT;
                        counter <= CNT_W'(LATENCY - 2);
                    end
                end
                WAIT: begin
                    if (counter == '0) begin
                        state      <= RESP;
                        rspValid   <= 1'b1;
                        rspIsWrite <= q_write[head];
                        rspID      <= q_id[head];
                        rspData    <= q_write[head] ? '0 : store[q_idx[head]];
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RESP: begin
                    if (rspReady) begin
                        state    <= IDLE;
                        rspValid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed self-checking bench for line_fill_responder with hand-computed responses.
module tb_line_fill_responder;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqIsWrite;
    logic [31:0] reqAddr;
    logic [63:0] reqWriteData;
    logic [0:0]  reqID;
    logic        rspValid;
    logic        rspReady;
    logic        rspIsWrite;
    logic [0:0]  rspID;
    logic [63:0] rspData;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D2 = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] D3 = 64'h0F0F_F0F0_1357_9BDF;
    localparam logic [63:0] D4 = 64'hDEAD_BEEF_CAFE_0001;
    localparam logic [63:0] D5 = 64'hFFFF_FFFF_FFFF_FFFF;

    line_fill_responder dut (
        .clk(clk),
        .rst(rst),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqIsWrite(reqIsWrite),
        .reqAddr(reqAddr),
        .reqWriteData(reqWriteData),
        .reqID(reqID),
        .rspValid(rspValid),
        .rspReady(rspReady),
        .rspIsWrite(rspIsWrite),
        .rspID(rspID),
        .rspData(rspData),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one request and hold it until accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [63:0] data, input logic [0:0] id);
        logic rdy;
        rdy          = 1'b0;
        reqValid     = 1'b1;
        reqIsWrite   = wr;
        reqAddr      = addr;
        reqWriteData = data;
        reqID        = id;
        for (int n = 0; n < 40; n++) begin
            rdy = reqReady;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        if (!rdy) checkOutput("accept_timeout", reqReady, 1'b1);
        reqValid = 1'b0;
    endtask

    // Wait for a response, check it, and let it pop when rspReady is high.
    task automatic collectResp(input string tag, input logic wr, input logic [0:0] id,
                               input logic [63:0] data, input int expLat);
        int lat;
        lat = 0;
        while (!rspValid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_valid"}, rspValid, 1'b1);
        checkOutput({tag, "_iswrite"}, rspIsWrite, wr);
        checkOutput({tag, "_id"}, rspID, id);
        checkOutput({tag, "_data"}, rspData, data);
        if (expLat >= 0) checkOutput({tag, "_latency"}, lat, expLat);
        if (rspReady) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_popped"}, rspValid, 1'b0);
        end
    endtask

    initial begin
        logic seen;
        rst          = 1'b1;
        reqValid     = 1'b0;
        reqIsWrite   = 1'b0;
        reqAddr      = '0;
        reqWriteData = '0;
        reqID        = '0;
        rspReady     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rspValid", rspValid, 1'b0);
        checkOutput("rst_reqReady", reqReady, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rspData", rspData, 64'h0);
        checkOutput("rst_rspID", rspID, 1'b0);
        checkOutput("rst_rspIsWrite", rspIsWrite, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Writeback then fill of the same line, exact latency from an idle responder.
        applyStimulus(1'b1, 32'h40, D1, 1'b1);
        checkOutput("wr_busy", busy, 1'b1);
        collectResp("wr_ack", 1'b1, 1'b1, 64'h0, 4);
        applyStimulus(1'b0, 32'h40, 64'h0, 1'b0);
        collectResp("rd_40", 1'b0, 1'b0, D1, 4);
        applyStimulus(1'b0, 32'h47, 64'h0, 1'b1);
        collectResp("rd_47", 1'b0, 1'b1, D1, 4);

        // Backpressure: fill the queue, stall the first response, then drain in order.
        rspReady = 1'b0;
        applyStimulus(1'b1, 32'h100, D2, 1'b0);
        applyStimulus(1'b1, 32'h108, D3, 1'b1);
        applyStimulus(1'b0, 32'h100, 64'h0, 1'b0);
        checkOutput("bp_ready_3", reqReady, 1'b1);
        applyStimulus(1'b0, 32'h108, 64'h0, 1'b1);
        checkOutput("bp_ready_full", reqReady, 1'b0);
        reqValid     = 1'b1;
        reqIsWrite   = 1'b0;
        reqAddr      = 32'h40;
        reqWriteData = '0;
        reqID        = 1'b0;
        collectResp("bp_first", 1'b1, 1'b0, 64'h0, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_valid", rspValid, 1'b1);
            checkOutput("stall_data", rspData, 64'h0);
            checkOutput("stall_id", rspID, 1'b0);
            checkOutput("stall_held_ready", reqReady, 1'b0);
        end
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_popped", rspValid, 1'b0);
        checkOutput("bp_ready_after_pop", reqReady, 1'b1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        checkOutput("bp_fifth_accepted", reqReady, 1'b0);
        collectResp("bp_second", 1'b1, 1'b1, 64'h0, 3);
        collectResp("bp_third", 1'b0, 1'b0, D2, 4);
        collectResp("bp_fourth", 1'b0, 1'b1, D3, 4);
        collectResp("bp_fifth", 1'b0, 1'b0, D1, 4);
        checkOutput("bp_idle", busy, 1'b0);

        // Address aliasing modulo the store size.
        applyStimulus(1'b1, 32'h2000, D4, 1'b1);
        collectResp("wrap_wr", 1'b1, 1'b1, 64'h0, 4);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0);
        collectResp("wrap_rd", 1'b0, 1'b0, D4, 4);
        applyStimulus(1'b0, 32'h2040, 64'h0, 1'b1);
        collectResp("wrap_rd_alias8", 1'b0, 1'b1, D1, 4);

        // Reset while the first of three requests is still waiting.
        applyStimulus(1'b1, 32'h40, D5, 1'b0);
        applyStimulus(1'b0, 32'h40, 64'h0, 1'b1);
        applyStimulus(1'b0, 32'h108, 64'h0, 1'b0);
        checkOutput("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_rspValid", rspValid, 1'b0);
        checkOutput("mid_rst_reqReady", reqReady, 1'b1);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            seen = seen | rspValid;
        end
        checkOutput("mid_no_response", seen, 1'b0);
        checkOutput("mid_idle", busy, 1'b0);
        applyStimulus(1'b0, 32'h40, 64'h0, 1'b1);
        collectResp("mid_line_kept", 1'b0, 1'b1, D1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
